// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fsk_pkg
// Brief   : Shared types and constants for the FSK transmit frame scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package fsk_pkg;

    // Frame scheduler states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_STOP     = 3'd4
    } state_t;

    // Default tone increments for mark (1) and space (0)
    localparam logic [23:0] DEF_MARK_INC  = 24'h0A3D71;
    localparam logic [23:0] DEF_SPACE_INC = 24'h051EB8;

    // Data bits per frame, sent LSB first
    localparam int DATA_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/fsk_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : fsk_baud_tick
// Brief   : Counts clock-enable strobes and flags the last strobe of a bit.
// Revision: 1.0 - initial release
// ============================================================================
module fsk_baud_tick #(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic bnd
);

    localparam logic [15:0] CNT_LAST = 16'(BAUD_DIV - 1);

    logic [15:0] baud_cnt_q;
    logic [15:0] baud_cnt_d;

    // Boundary on the last strobe of a bit; clear wins over a coincident strobe
    always_comb begin
        bnd        = en && (baud_cnt_q == CNT_LAST);
        baud_cnt_d = baud_cnt_q;
        if (clr || bnd) begin
            baud_cnt_d = '0;
        end else if (en) begin
            baud_cnt_d = baud_cnt_q + 16'd1;
        end
    end

    // Strobe counter register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fsk_tx_ctrl
// Brief   : Frames bytes as preamble/start/8 data/stop and drives FSK tones.
// Revision: 1.0 - initial release
// ============================================================================
module fsk_tx_ctrl
    import fsk_pkg::*;
#(
    parameter int unsigned      BAUD_DIV      = 16,
    parameter int unsigned      PREAMBLE_BITS = 8,
    parameter int unsigned      TONE_W        = 24,
    parameter logic [TONE_W-1:0] MARK_INC     = TONE_W'(DEF_MARK_INC),
    parameter logic [TONE_W-1:0] SPACE_INC    = TONE_W'(DEF_SPACE_INC)
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              en,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [TONE_W-1:0] tone_inc,
    output logic              tone_en,
    output logic              bit_out,
    output logic              busy
);

    localparam logic [15:0] PRE_LAST  = (PREAMBLE_BITS > 0) ? 16'(PREAMBLE_BITS - 1) : 16'd0;
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       pre_cnt_q, pre_cnt_d;
    logic              bit_out_q, bit_out_d;
    logic [TONE_W-1:0] tone_inc_q;
    logic              tone_en_q;
    logic              busy_q;
    logic              bnd;
    logic              accept;

    // Strobe counter is held at zero while idle so a new burst starts clean
    fsk_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (en),
        .clr    (state_q == ST_IDLE),
        .bnd    (bnd)
    );

    // Ready while idle, or on the final strobe of a stop bit for back-to-back frames
    always_comb begin
        tx_ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bnd);
        accept   = tx_valid && tx_ready;
    end

    // Next-state and next-line-bit logic; the line bit is produced with the state
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        bit_out_d = bit_out_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = tx_data;
                    pre_cnt_d = '0;
                    if (PREAMBLE_BITS > 0) begin
                        state_d   = ST_PREAMBLE;
                        bit_out_d = 1'b1;
                    end else begin
                        state_d   = ST_START;
                        bit_out_d = 1'b0;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (bnd) begin
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d   = ST_START;
                        bit_out_d = 1'b0;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 16'd1;
                        bit_out_d = ~bit_out_q;
                    end
                end
            end
            ST_START: begin
                if (bnd) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    bit_out_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bnd) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = ST_STOP;
                        bit_out_d = 1'b1;
                    end else begin
                        bit_out_d = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (bnd) begin
                    if (accept) begin
                        shift_d   = tx_data;
                        state_d   = ST_START;
                        bit_out_d = 1'b0;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_out_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_out_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; tone follows the line bit on the same edge
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            bit_out_q  <= 1'b1;
            tone_inc_q <= MARK_INC;
            tone_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_out_q  <= bit_out_d;
            tone_inc_q <= bit_out_d ? MARK_INC : SPACE_INC;
            tone_en_q  <= (state_d != ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign tone_inc = tone_inc_q;
    assign tone_en  = tone_en_q;
    assign bit_out  = bit_out_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsk_tx_ctrl
// Brief   : Self-checking bench; two scheduler instances against a bit-queue model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fsk_tx_ctrl;

    localparam logic [23:0] MARK  = 24'h0A3D71;
    localparam logic [23:0] SPACE = 24'h051EB8;
    localparam int NB = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en_s    [2];
    logic        valid_s [2];
    logic [7:0]  data_s  [2];
    logic        ready_s [2];
    logic [23:0] inc_s   [2];
    logic        ten_s   [2];
    logic        bit_s   [2];
    logic        busy_s  [2];

    // Instance 0: 4 strobes per bit with a 2-bit preamble
    fsk_tx_ctrl #(.BAUD_DIV(4), .PREAMBLE_BITS(2), .TONE_W(24),
                  .MARK_INC(MARK), .SPACE_INC(SPACE)) u_dut0 (
        .clk_in(clk), .reset(rst), .en(en_s[0]), .tx_data(data_s[0]),
        .tx_valid(valid_s[0]), .tx_ready(ready_s[0]), .tone_inc(inc_s[0]),
        .tone_en(ten_s[0]), .bit_out(bit_s[0]), .busy(busy_s[0]));

    // Instance 1: one strobe per bit, no preamble
    fsk_tx_ctrl #(.BAUD_DIV(1), .PREAMBLE_BITS(0), .TONE_W(24),
                  .MARK_INC(MARK), .SPACE_INC(SPACE)) u_dut1 (
        .clk_in(clk), .reset(rst), .en(en_s[1]), .tx_data(data_s[1]),
        .tx_valid(valid_s[1]), .tx_ready(ready_s[1]), .tone_inc(inc_s[1]),
        .tone_en(ten_s[1]), .bit_out(bit_s[1]), .busy(busy_s[1]));

    function automatic int bd_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int pb_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Model: circular queue of line bits still to be sent, plus strobes spent on the head bit
    bit         seq  [2][NB];
    int         hd   [2];
    int         ln   [2];
    int         cnt  [2];
    // Upstream: bytes waiting to be offered
    logic [7:0] pend [2][NB];
    int         prd  [2];
    int         pwr  [2];
    bit         vheld[2];
    int         en_mode[2];
    bit         rnd_valid;
    int         bcnt [2];
    int         cyc;
    bit         chk_on;
    int         checks;
    int         errors;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc %0d got %0h expected %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic push_bit(input int k, input bit b);
        seq[k][(hd[k] + ln[k]) % NB] = b;
        ln[k]++;
    endtask

    task automatic send(input int k, input logic [7:0] b);
        pend[k][pwr[k]] = b;
        pwr[k] = (pwr[k] + 1) % NB;
    endtask

    // Compare outputs for the current cycle, then advance the model over the coming edge
    task automatic model_cycle(input int k);
        bit busy, bnd, rdy, eb, acc;
        busy = (ln[k] > 0);
        bnd  = busy && (en_s[k] === 1'b1) && (cnt[k] == bd_of(k) - 1);
        rdy  = !busy || (ln[k] == 1 && bnd);
        eb   = busy ? seq[k][hd[k]] : 1'b1;
        if (chk_on) begin
            chk("tx_ready", k, 32'(ready_s[k]), 32'(rdy));
            chk("bit_out",  k, 32'(bit_s[k]),   32'(eb));
            chk("tone_inc", k, 32'(inc_s[k]),   eb ? 32'(MARK) : 32'(SPACE));
            chk("tone_en",  k, 32'(ten_s[k]),   32'(busy));
            chk("busy",     k, 32'(busy_s[k]),  32'(busy));
        end
        if (busy_s[k] === 1'b1) bcnt[k]++;
        acc = (valid_s[k] === 1'b1) && rdy && !rst;
        if (rst) begin
            ln[k]  = 0;
            cnt[k] = 0;
        end else begin
            if (busy) begin
                if (bnd) begin
                    hd[k]  = (hd[k] + 1) % NB;
                    ln[k]--;
                    cnt[k] = 0;
                end else if (en_s[k] === 1'b1) begin
                    cnt[k]++;
                end
            end
            if (acc) begin
                if (!busy) begin
                    for (int i = 0; i < pb_of(k); i++) push_bit(k, (i % 2) == 0);
                end
                push_bit(k, 1'b0);
                for (int i = 0; i < 8; i++) push_bit(k, data_s[k][i]);
                push_bit(k, 1'b1);
                cnt[k]   = 0;
                prd[k]   = (prd[k] + 1) % NB;
                vheld[k] = 1'b0;
            end
        end
    endtask

    task automatic drive(input int k);
        case (en_mode[k])
            0:       en_s[k] = 1'b1;
            1:       en_s[k] = ((cyc % 5) == 0);
            default: en_s[k] = 1'($urandom % 2);
        endcase
        if (prd[k] != pwr[k] && !vheld[k]) begin
            if (!rnd_valid || ($urandom % 3) == 0) vheld[k] = 1'b1;
        end
        valid_s[k] = vheld[k];
        data_s[k]  = vheld[k] ? pend[k][prd[k]] : 8'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_cycle(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) drive(k);
    endtask

    task automatic run_idle(input int k, input int limit);
        int n;
        n = 0;
        while ((prd[k] != pwr[k] || ln[k] != 0) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $error("FAIL timeout dut%0d got %0d cycles expected below %0d", k, n, limit);
        end
        repeat (3) step();
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; chk_on = 1'b0; rnd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hd[k] = 0; ln[k] = 0; cnt[k] = 0; prd[k] = 0; pwr[k] = 0;
            vheld[k] = 1'b0; en_mode[k] = 0; bcnt[k] = 0;
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) drive(k);

        // Reset with en high, then idle outputs must hold
        repeat (2) step();
        rst = 1'b0;
        chk_on = 1'b1;
        repeat (20) step();

        // Single frame, 12 bits x 4 cycles
        bcnt[0] = 0;
        send(0, 8'hA5);
        run_idle(0, 200);
        chk("len_a5", 0, 32'(bcnt[0]), 32'd48);

        // Back-to-back frames, preamble only once
        bcnt[0] = 0;
        send(0, 8'h00);
        send(0, 8'hFF);
        run_idle(0, 300);
        chk("len_b2b", 0, 32'(bcnt[0]), 32'd88);

        // Enable every fifth cycle: bits stretch to 20 cycles
        en_mode[0] = 1;
        send(0, 8'h5A);
        run_idle(0, 1000);
        en_mode[0] = 0;

        // Reset during data bit 3 of 0x3C
        send(0, 8'h3C);
        n = 0;
        while (ln[0] == 0 && n < 20) begin
            step();
            n++;
        end
        repeat (25) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_len", 0, 32'(ln[0]), 32'd0);
        bcnt[0] = 0;
        send(0, 8'h81);
        run_idle(0, 200);
        chk("len_81", 0, 32'(bcnt[0]), 32'd48);

        // One strobe per bit, no preamble: 10-cycle frame
        bcnt[1] = 0;
        send(1, 8'h01);
        run_idle(1, 100);
        chk("len_01", 1, 32'(bcnt[1]), 32'd10);

        // Random bytes, random enables, random valid delays on both instances
        rnd_valid  = 1'b1;
        en_mode[0] = 2;
        en_mode[1] = 2;
        for (int i = 0; i < 16; i++) begin
            send(0, 8'($urandom));
            send(1, 8'($urandom));
        end
        n = 0;
        while ((prd[0] != pwr[0] || ln[0] != 0 || prd[1] != pwr[1] || ln[1] != 0) && n < 8000) begin
            step();
            n++;
        end
        if (n >= 8000) begin
            checks++;
            errors++;
            $error("FAIL timeout_random got %0d cycles expected below 8000", n);
        end
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fsk_tx_ctrl.md
Name: fsk_tx_ctrl

Overview:
Frame scheduler for the FSK transmitter. It accepts bytes over a valid/ready handshake and frames each one as optional preamble, start bit, 8 data bits LSB-first and stop bit. For each bit it drives the mark or space tone increment to the tone generator, holding every bit for BAUD_DIV strobes of the clock-enable produced by the 6.25-to-5 MHz divider path.

Parameters:
BAUD_DIV, 16, enable strobes per bit; legal range 1..65535.
PREAMBLE_BITS, 8, alternating 1/0 bits sent before the first frame of a burst; 0 means no preamble.
TONE_W, 24, width of the tone increment word.
MARK_INC, 24'h0A3D71, tone increment for bit 1 (mark).
SPACE_INC, 24'h051EB8, tone increment for bit 0 (space).

Ports:
clk_in  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
en  in  1  one-cycle clock-enable strobe from the divider; the baud count advances only when en=1.
tx_data  in  8  byte to send.
tx_valid  in  1  tx_data is valid; upstream holds tx_valid and tx_data until accepted.
tx_ready  out  1  the block can accept a byte this cycle.
tone_inc  out  TONE_W  increment for the current bit (MARK_INC or SPACE_INC).
tone_en  out  1  tone generator enable; 1 for the whole burst.
bit_out  out  1  current line bit, for debug and monitoring.
busy  out  1  1 in any state other than IDLE.

Behaviour:
- Single clock clk_in. reset is synchronous and active-high and takes priority over every other input.
- Reset values: state=IDLE, tx_ready=1, tone_en=0, tone_inc=MARK_INC, bit_out=1, busy=0. The baud counter, bit counter and shift register are all cleared to 0.
- States: IDLE, PREAMBLE, START, DATA, STOP.
- Bit boundary (bnd) = en && (baud_cnt == BAUD_DIV-1).
  - On bnd, baud_cnt returns to 0. On en without bnd, baud_cnt increments.
  - When en=0, baud_cnt holds.
- tx_ready (combinational) = (state==IDLE) || (state==STOP && bnd).
- Accept = tx_valid && tx_ready. On accept, tx_data is captured into the shift register.
- IDLE:
  - On accept, the next state is PREAMBLE if PREAMBLE_BITS>0, otherwise START.
  - On the same accepting edge: baud_cnt cleared, tone_en=1 and busy=1, both taking effect in the next cycle.
  - Latency: accept at cycle t gives the first bit on tone_inc/bit_out at cycle t+1.
- PREAMBLE:
  - bit_out = 1 for the first preamble bit, then alternates.
  - After PREAMBLE_BITS boundaries the block moves to START.
- START: bit_out=0. On bnd, move to DATA with bit_cnt=0.
- DATA:
  - bit_out = shift[0]. On bnd the shift register shifts right and bit_cnt increments.
  - On the bnd with bit_cnt==7, move to STOP.
- STOP: bit_out=1. On bnd:
  - If a byte is accepted (back-to-back), go to START directly. No preamble is sent within a burst.
  - Otherwise go to IDLE, with tone_en=0, busy=0 and tone_inc=MARK_INC.
- tone_inc = bit_out ? MARK_INC : SPACE_INC. It is registered, so it updates on the same edge as bit_out.
- Each bit lasts exactly BAUD_DIV en strobes. With en tied high, a bit lasts BAUD_DIV clk_in cycles.
- BAUD_DIV=1: every en strobe is a bit boundary.
- tx_valid during non-ready cycles is ignored; nothing is lost because upstream holds it.
- Reset mid-frame: the frame is aborted. All outputs show reset values in the cycle after the reset edge, and the partial byte is discarded.
- en and accept in the same IDLE cycle: accept wins and baud_cnt starts from 0; that en is not counted.

Decomposition:
- Package fsk_pkg:
  - state enum (IDLE, PREAMBLE, START, DATA, STOP);
  - default MARK_INC/SPACE_INC constants;
  - frame-length constant (DATA_BITS=8).
- Sub-module fsk_baud_tick:
  - parameter BAUD_DIV; inputs clk_in, reset, en, clr;
  - output bnd, with the counter held internally.
  - Instantiated once; the FSM stays in fsk_tx_ctrl.

Test Plan:
- Reset check: pulse reset for 2 cycles with en=1 and tx_valid=0 -> tx_ready=1, tone_en=0, tone_inc=MARK_INC, bit_out=1, busy=0, held for 20 cycles.
- Single frame: BAUD_DIV=4, PREAMBLE_BITS=2, en=1, send tx_data=8'hA5 -> bit_out sequence 1,0 | 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles. The burst lasts 48 cycles, then IDLE with tone_en=0. tone_inc matches bit_out in every cycle.
- Back-to-back: tx_valid held with 8'h00 then 8'hFF -> the second byte is accepted in the last STOP cycle, START follows with no preamble, and there is no gap. Total length 2+10+10 bits = 88 cycles.
- Enable gating: en asserted every 5th cycle, BAUD_DIV=2 -> each bit lasts exactly 10 clk_in cycles, and baud_cnt holds between strobes.
- Reset mid-frame: assert reset during DATA bit 3 of 8'h3C -> the next cycle shows reset values. A new byte 8'h81 afterwards produces a clean full frame with preamble.
- Boundary: BAUD_DIV=1, PREAMBLE_BITS=0, en=1, tx_data=8'h01 -> a 10-cycle frame 0,1,0,0,0,0,0,0,0,1, and tx_ready=1 in the final STOP cycle.
